// File: rtl/alu_slice_seq_pkg.sv
// rtl/alu_slice_seq_pkg.sv - shared types and helpers for the sliced sequential ALU
package alu_slice_seq_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_PLUS4 = 4'd2,
    ALU_AND   = 4'd3,
    ALU_OR    = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_EQ    = 4'd9,
    ALU_LT    = 4'd10,
    ALU_LTU   = 4'd11
  } cs_alu_op;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } alu_seq_state_e;

  // Compare ops produce a single-bit outcome instead of a sliced result.
  function automatic logic is_cmp_op(input cs_alu_op op);
    return (op == ALU_EQ) || (op == ALU_LT) || (op == ALU_LTU);
  endfunction

  // Ops that run the subtract path need the carry chain seeded with 1.
  function automatic logic is_sub_like(input cs_alu_op op);
    return (op == ALU_SUB) || (op == ALU_LT) || (op == ALU_LTU);
  endfunction

endpackage

// File: rtl/alu_slice_seq_if.sv
// rtl/alu_slice_seq_if.sv - request/result handshake bundle of the sliced ALU
interface alu_slice_seq_if
  import alu_slice_seq_pkg::*;
#(
  parameter int XLEN = 32
);

  logic            req_valid_i;
  logic            req_ready_o;
  cs_alu_op        op_i;
  logic            cmp_flip_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            res_valid_o;
  logic            res_ready_i;
  logic [XLEN-1:0] result_o;
  logic            cmp_result_o;

  modport slave (
    input  req_valid_i, op_i, cmp_flip_i, a_i, b_i, res_ready_i,
    output req_ready_o, res_valid_o, result_o, cmp_result_o
  );

  modport master (
    output req_valid_i, op_i, cmp_flip_i, a_i, b_i, res_ready_i,
    input  req_ready_o, res_valid_o, result_o, cmp_result_o
  );

endinterface

// File: rtl/alu_slice_seq_dp.sv
// rtl/alu_slice_seq_dp.sv - combinational one-slice datapath of the sliced ALU
module alu_slice_dp
  import alu_slice_seq_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  cs_alu_op                     op,
  input  logic [SLICE_W-1:0]           a_s,
  input  logic [SLICE_W-1:0]           b_s,
  input  logic                         carry_i,
  input  logic [SLICE_W-1:0]           fun_hi,
  input  logic [SLICE_W-1:0]           fun_lo,
  input  logic [$clog2(SLICE_W)-1:0]   r,
  output logic [SLICE_W-1:0]           res,
  output logic                         carry_o,
  output logic                         mismatch
);

  logic [SLICE_W:0]     sum_add;
  logic [SLICE_W:0]     sum_sub;
  logic [2*SLICE_W-1:0] fun;
  logic [2*SLICE_W-1:0] fun_r;
  logic [2*SLICE_W-1:0] fun_l;

  // Slice arithmetic, funnel shift and equality per operation.
  always_comb begin
    sum_add  = {1'b0, a_s} + {1'b0, b_s} + {{SLICE_W{1'b0}}, carry_i};
    sum_sub  = {1'b0, a_s} + {1'b0, ~b_s} + {{SLICE_W{1'b0}}, carry_i};
    fun      = {fun_hi, fun_lo};
    fun_r    = fun >> r;
    fun_l    = fun << r;
    mismatch = (a_s != b_s);
    res      = '0;
    carry_o  = 1'b0;
    case (op)
      ALU_ADD, ALU_PLUS4:       {carry_o, res} = sum_add;
      ALU_SUB, ALU_LT, ALU_LTU: {carry_o, res} = sum_sub;
      ALU_AND:                  res = a_s & b_s;
      ALU_OR:                   res = a_s | b_s;
      ALU_XOR:                  res = a_s ^ b_s;
      ALU_SRL, ALU_SRA:         res = fun_r[SLICE_W-1:0];
      ALU_SLL:                  res = fun_l[2*SLICE_W-1:SLICE_W];
      default:                  res = '0;
    endcase
  end

endmodule

// File: rtl/alu_slice_seq.sv
// rtl/alu_slice_seq.sv - multi-cycle ALU processing one operand slice per clock
module alu_slice_seq
  import alu_slice_seq_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SLICE_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  alu_slice_seq_if.slave  bus
);

  localparam int NSLICE = XLEN / SLICE_W;
  localparam int CW     = $clog2(NSLICE);
  localparam int SHW    = $clog2(XLEN);
  localparam int RW     = $clog2(SLICE_W);

  alu_seq_state_e  state, state_n;
  logic [CW-1:0]   cnt;
  logic            carry;
  cs_alu_op        op_q;
  logic            flip_q;
  logic [XLEN-1:0] a_q, b_q, result_q;
  logic            cmp_q;

  int              k_idx, q_idx;
  logic [RW-1:0]   r_amt;
  logic            fill;
  logic [SLICE_W-1:0] a_s, b_s, b_eff, fun_hi, fun_lo, slice_res;
  logic            carry_o, mismatch, last, finish, cmp_raw, cmp_now;

  // Out-of-range slice indices read as the fill pattern.
  function automatic logic [SLICE_W-1:0] slice_of(input logic [XLEN-1:0] v, input int idx,
                                                  input logic fill_bit);
    if (idx < 0 || idx >= NSLICE) return {SLICE_W{fill_bit}};
    return v[idx*SLICE_W +: SLICE_W];
  endfunction

  // Select the operand and funnel slices for the current counter value.
  always_comb begin
    k_idx = int'(cnt);
    q_idx = int'(b_q[SHW-1:RW]);
    r_amt = b_q[RW-1:0];
    fill  = (op_q == ALU_SRA) & a_q[XLEN-1];
    a_s   = slice_of(a_q, k_idx, 1'b0);
    b_s   = slice_of(b_q, k_idx, 1'b0);
    b_eff = b_s;
    if (op_q == ALU_PLUS4) b_eff = (cnt == '0) ? SLICE_W'(4) : '0;
    if (op_q == ALU_SLL) begin
      fun_hi = slice_of(a_q, k_idx - q_idx, 1'b0);
      fun_lo = slice_of(a_q, k_idx - q_idx - 1, 1'b0);
    end else begin
      fun_hi = slice_of(a_q, k_idx + q_idx + 1, fill);
      fun_lo = slice_of(a_q, k_idx + q_idx, fill);
    end
  end

  alu_slice_dp #(.SLICE_W(SLICE_W)) u_dp (
    .op       (op_q),
    .a_s      (a_s),
    .b_s      (b_eff),
    .carry_i  (carry),
    .fun_hi   (fun_hi),
    .fun_lo   (fun_lo),
    .r        (r_amt),
    .res      (slice_res),
    .carry_o  (carry_o),
    .mismatch (mismatch)
  );

  // Compare outcome; LT/LTU are only meaningful on the last slice.
  always_comb begin
    last    = (cnt == CW'(NSLICE - 1));
    finish  = last || (op_q == ALU_EQ && mismatch);
    cmp_raw = 1'b0;
    case (op_q)
      ALU_EQ:  cmp_raw = ~mismatch;
      ALU_LT:  cmp_raw = (a_s[SLICE_W-1] != b_s[SLICE_W-1]) ? a_s[SLICE_W-1]
                                                             : slice_res[SLICE_W-1];
      ALU_LTU: cmp_raw = ~carry_o;
      default: cmp_raw = 1'b0;
    endcase
    cmp_now = cmp_raw ^ flip_q;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_n         = state;
    bus.req_ready_o = 1'b0;
    bus.res_valid_o = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) state_n = EXEC;
      end
      EXEC: if (finish) state_n = DONE;
      DONE: begin
        bus.res_valid_o = 1'b1;
        if (bus.res_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand latch, slice counter, carry chain and result assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      carry    <= 1'b0;
      op_q     <= ALU_ADD;
      flip_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cmp_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid_i) begin
          op_q   <= bus.op_i;
          flip_q <= bus.cmp_flip_i;
          a_q    <= bus.a_i;
          b_q    <= bus.b_i;
          cnt    <= '0;
          carry  <= is_sub_like(bus.op_i);
          cmp_q  <= 1'b0;
        end
        EXEC: begin
          cnt   <= cnt + 1'b1;
          carry <= carry_o;
          if (!is_cmp_op(op_q)) begin
            result_q[k_idx*SLICE_W +: SLICE_W] <= slice_res;
          end else if (finish) begin
            cmp_q    <= cmp_now;
            result_q <= {{(XLEN-1){1'b0}}, cmp_now};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result_o     = result_q;
  assign bus.cmp_result_o = cmp_q;

endmodule

// File: tb/tb_alu_slice_seq.sv
// tb/tb_alu_slice_seq.sv - directed vector bench for the sliced sequential ALU
module tb_alu_slice_seq;
  import alu_slice_seq_pkg::*;

  typedef struct {
    string       name;
    cs_alu_op    op;
    logic        flip;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cmp;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  alu_slice_seq_if #(.XLEN(32)) bus ();

  alu_slice_seq #(.XLEN(32), .SLICE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input cs_alu_op op, input logic flip,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                     input logic cmp, input int lat);
    vec_t v;
    v.name = name; v.op = op; v.flip = flip; v.a = a; v.b = b;
    v.res = res; v.cmp = cmp; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.res_valid_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input cs_alu_op op, input logic flip, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output logic cmp,
                        output int lat);
    int g = 0;
    @(negedge clk);
    while (!bus.req_ready_o && g < 50) begin
      @(negedge clk); g++;
    end
    bus.req_valid_i = 1'b1;
    bus.op_i        = op;
    bus.cmp_flip_i  = flip;
    bus.a_i         = a;
    bus.b_i         = b;
    bus.res_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    wait_valid(lat);
    res = bus.result_o;
    cmp = bus.cmp_result_o;
    @(posedge clk); #1;
    bus.res_ready_i = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic        cmp;
    int          lat;

    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.op_i        = ALU_ADD;
    bus.cmp_flip_i  = 1'b0;
    bus.a_i         = '0;
    bus.b_i         = '0;
    bus.res_ready_i = 1'b0;

    add("add_ff_1",   ALU_ADD,   0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 0, 4);
    add("add_wrap",   ALU_ADD,   0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0, 4);
    add("sub_5_7",    ALU_SUB,   0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 0, 4);
    add("plus4",      ALU_PLUS4, 0, 32'h0000_00FE, 32'h0000_0000, 32'h0000_0102, 0, 4);
    add("plus4_wrap", ALU_PLUS4, 0, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0000_0000, 0, 4);
    add("and",        ALU_AND,   0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0, 4);
    add("or",         ALU_OR,    0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 0, 4);
    add("xor",        ALU_XOR,   0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 0, 4);
    add("lt_m1_1",    ALU_LT,    0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, 4);
    add("ltu_m1_1",   ALU_LTU,   0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0, 4);
    add("geu_m1_1",   ALU_LTU,   1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, 4);
    add("lt_1_m1",    ALU_LT,    0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 0, 4);
    add("ltu_1_m1",   ALU_LTU,   0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1, 4);
    add("lt_eq",      ALU_LT,    0, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 0, 4);
    add("lt_m2_m1",   ALU_LT,    0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001, 1, 4);
    add("lt_maxneg",  ALU_LT,    0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 0, 4);
    add("eq_early0",  ALU_EQ,    0, 32'h0000_0012, 32'h0000_0013, 32'h0000_0000, 0, 1);
    add("eq_equal",   ALU_EQ,    0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0001, 1, 4);
    add("ne_equal",   ALU_EQ,    1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 0, 4);
    add("ne_early2",  ALU_EQ,    1, 32'h0012_0000, 32'h0000_0000, 32'h0000_0001, 1, 3);
    add("sra_12",     ALU_SRA,   0, 32'h8000_0000, 32'd12,        32'hFFF8_0000, 0, 4);
    add("sra_31",     ALU_SRA,   0, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 0, 4);
    add("sra_pos",    ALU_SRA,   0, 32'h4000_0000, 32'd4,         32'h0400_0000, 0, 4);
    add("sll_9",      ALU_SLL,   0, 32'h0000_00F1, 32'd9,         32'h0001_E200, 0, 4);
    add("sll_31",     ALU_SLL,   0, 32'h0000_0001, 32'd31,        32'h8000_0000, 0, 4);
    add("srl_31",     ALU_SRL,   0, 32'h8000_0000, 32'd31,        32'h0000_0001, 0, 4);
    add("srl_8",      ALU_SRL,   0, 32'hAABB_CCDD, 32'd8,         32'h00AA_BBCC, 0, 4);
    add("sll_0",      ALU_SLL,   0, 32'h1234_5678, 32'd0,         32'h1234_5678, 0, 4);
    add("sra_hi_ign", ALU_SRA,   0, 32'h8234_5678, 32'h0000_0100, 32'h8234_5678, 0, 4);
    add("unknown",    cs_alu_op'(4'd13), 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0, 4);

    // Reset values while reset is held.
    #12;
    chk("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid_o), 32'd0);
    chk("rst_result", bus.result_o, 32'h0);
    chk("rst_cmp", 32'(bus.cmp_result_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].flip, vecs[i].a, vecs[i].b, res, cmp, lat);
      chk({vecs[i].name, ".res"}, res, vecs[i].res);
      chk({vecs[i].name, ".cmp"}, 32'(cmp), 32'(vecs[i].cmp));
      chk({vecs[i].name, ".lat"}, 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure in DONE: result held, new requests ignored, one bubble on release.
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.op_i = ALU_ADD; bus.cmp_flip_i = 1'b0;
    bus.a_i = 32'd2; bus.b_i = 32'd3; bus.res_ready_i = 1'b0;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    wait_valid(lat);
    chk("bp_lat", 32'(lat), 32'd4);
    bus.req_valid_i = 1'b1; bus.a_i = 32'd10; bus.b_i = 32'd20;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_result", bus.result_o, 32'd5);
      chk("bp_hold_ready", 32'(bus.req_ready_o), 32'd0);
      chk("bp_hold_valid", 32'(bus.res_valid_o), 32'd1);
    end
    @(negedge clk);
    bus.res_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.res_ready_i = 1'b0;
    chk("bp_bubble_valid", 32'(bus.res_valid_o), 32'd0);
    chk("bp_bubble_ready", 32'(bus.req_ready_o), 32'd1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    chk("bp_accept_ready", 32'(bus.req_ready_o), 32'd0);
    wait_valid(lat);
    chk("bp_next_lat", 32'(lat), 32'd4);
    chk("bp_next_result", bus.result_o, 32'd30);
    @(negedge clk);
    bus.res_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.res_ready_i = 1'b0;

    // Asynchronous reset in the middle of a SUB.
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.op_i = ALU_SUB;
    bus.a_i = 32'd5; bus.b_i = 32'd7;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", 32'(bus.req_ready_o), 32'd1);
    chk("mid_rst_res_valid", 32'(bus.res_valid_o), 32'd0);
    chk("mid_rst_result", bus.result_o, 32'h0);
    chk("mid_rst_cmp", 32'(bus.cmp_result_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(ALU_ADD, 1'b0, 32'd2, 32'd3, res, cmp, lat);
    chk("post_rst_add", res, 32'h0000_0005);
    chk("post_rst_lat", 32'(lat), 32'd4);
    chk("post_rst_cmp", 32'(cmp), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
